// File: rtl/timer_nbit_v2.sv
// timer_nbit_v2: N-bit general-purpose timer with prescaler, auto-reload period,
// up / down / centre-aligned counting, one-shot mode, NUM_CH sticky match
// channels and a registered interrupt. Runs entirely on sys_clk with a
// synchronous tick enable.
// Optional macro TMR_PWM_EN: registered per-channel compare outputs on pwm_o.
// Without it, pwm_o is tied low and the PWM comparators are not built.
module timer_nbit_v2 #(
    parameter int N      = 32,
    parameter int NUM_CH = 4,
    parameter int PSC_W  = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  sys_clk_en,
    input  logic                  cfg_on,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_one_shot,
    input  logic [PSC_W-1:0]      cfg_psc,
    input  logic [N-1:0]          cfg_period,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  cmd_ld,
    input  logic [N-1:0]          ld_val,
    input  logic [NUM_CH*N-1:0]   match_val,
    input  logic [NUM_CH-1:0]     match_en,
    input  logic                  ovf_en,
    input  logic [NUM_CH:0]       flag_clr,
    output logic [N-1:0]          tmr_value,
    output logic                  running,
    output logic                  dir,
    output logic [NUM_CH-1:0]     match_flag,
    output logic                  ovf_flag,
    output logic                  irq,
    output logic [NUM_CH-1:0]     pwm_o
);

    localparam logic [N-1:0]     CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     CNT_MAX = {N{1'b1}};
    localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

    logic [PSC_W-1:0]  psc_cnt;
    logic              psc_hit;
    logic              tick;
    logic              upd;
    logic [N-1:0]      step_val;
    logic              step_dir;
    logic              step_wrap;
    logic [N-1:0]      val_d;
    logic              dir_d;
    logic              wrap_ev;
    logic [NUM_CH-1:0] match_hit;

    assign psc_hit = (psc_cnt == cfg_psc);
    assign tick    = cfg_on & running & sys_clk_en & psc_hit;
    // A load in the same cycle as a tick suppresses the count step and its events.
    assign upd     = tick & ~cmd_ld;
    assign wrap_ev = upd & step_wrap;

    // Next count value, direction and wrap for a tick, by mode.
    // Up/down: dir flips to 1 on reaching the top and back to 0 on reaching
    // the bottom; wrap is only signalled on reaching the bottom.
    always_comb begin
        step_val  = tmr_value;
        step_dir  = dir;
        step_wrap = 1'b0;
        if (cfg_period == '0) begin
            step_val  = '0;
            step_dir  = 1'b0;
            step_wrap = 1'b1;
        end else begin
            case (cfg_mode)
                2'b01: begin
                    step_dir = 1'b1;
                    if (tmr_value == '0) begin
                        step_val  = cfg_period;
                        step_wrap = 1'b1;
                    end else begin
                        step_val = tmr_value - CNT_ONE;
                    end
                end
                2'b10: begin
                    if (!dir && tmr_value < cfg_period) begin
                        step_val = tmr_value + CNT_ONE;
                        step_dir = (step_val == cfg_period);
                    end else if (dir && tmr_value == '0) begin
                        // Only reachable after a mid-count config change.
                        step_val = CNT_ONE;
                        step_dir = (step_val >= cfg_period);
                    end else begin
                        // Counting down, or loaded at/above the top while counting up.
                        step_val  = tmr_value - CNT_ONE;
                        step_wrap = (step_val == '0);
                        step_dir  = ~step_wrap;
                    end
                end
                default: begin
                    step_dir = 1'b0;
                    if (tmr_value == cfg_period || tmr_value == CNT_MAX) begin
                        step_val  = '0;
                        step_wrap = 1'b1;
                    end else begin
                        step_val = tmr_value + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Register-input values for count and direction (load beats tick).
    always_comb begin
        val_d = tmr_value;
        dir_d = dir;
        if (cmd_ld) begin
            val_d = ld_val;
            if (cfg_mode == 2'b10) begin
                dir_d = 1'b0;
            end
        end else if (tick) begin
            val_d = step_val;
            dir_d = step_dir;
        end
    end

    // Per-channel match detection on tick-driven updates only.
    always_comb begin
        match_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            match_hit[i] = upd & (step_val == match_val[i*N +: N]);
        end
    end

    // Run control: stop beats start, disable forces stop, one-shot stops on wrap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            running <= 1'b0;
        end else if (!cfg_on) begin
            running <= 1'b0;
        end else if (cmd_stop) begin
            running <= 1'b0;
        end else if (cmd_start) begin
            running <= 1'b1;
        end else if (wrap_ev && cfg_one_shot) begin
            running <= 1'b0;
        end
    end

    // Prescaler: counts enabled cycles, restarts on terminal count, start, load or disable.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            psc_cnt <= '0;
        end else if (!cfg_on || cmd_start || cmd_ld) begin
            psc_cnt <= '0;
        end else if (running && sys_clk_en) begin
            psc_cnt <= psc_hit ? '0 : psc_cnt + PSC_ONE;
        end
    end

    // Count value and direction registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmr_value <= '0;
            dir       <= 1'b0;
        end else begin
            tmr_value <= val_d;
            dir       <= dir_d;
        end
    end

    // Sticky flags: a same-cycle set beats the W1C clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            match_flag <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            match_flag <= (match_flag & ~flag_clr[NUM_CH-1:0]) | match_hit;
            ovf_flag   <= (ovf_flag & ~flag_clr[NUM_CH]) | wrap_ev;
        end
    end

    // Interrupt is built from the registered flags, so it trails them by a cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= (|(match_flag & match_en)) | (ovf_flag & ovf_en);
        end
    end

`ifdef TMR_PWM_EN
    logic [NUM_CH-1:0] pwm_d;

    // PWM compare against the value tmr_value is about to take, so pwm_o lines up with it.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = cfg_on & (val_d < match_val[i*N +: N]);
        end
    end

    // PWM output register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_o <= '0;
        end else begin
            pwm_o <= pwm_d;
        end
    end
`else
    assign pwm_o = '0;
`endif

endmodule
